// File: rtl/handshake_rr_seq.sv
// Round-robin start/ready/done sequencer: grants one of N_CH ready channels, strobes start, waits for done or timeout.
// Latency ready->start 1 cycle; requesters are held off (no grant) while a transaction is in START or WAIT.
module handshake_rr_seq #(
  parameter int N_CH      = 4,
  parameter int START_LEN = 1,
  parameter int TO_W      = 16,
  parameter int TIMEOUT   = 1000,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ready,
  input  logic [N_CH-1:0] done,
  input  logic [N_CH-1:0] en_mask,
  input  logic            err_clr,
  output logic [N_CH-1:0] start,
  output logic            busy,
  output logic [CH_W-1:0] grant_id,
  output logic            cmpl,
  output logic            to_pulse,
  output logic            err,
  output logic [CH_W-1:0] err_ch
);

  localparam int SL_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   start_q, start_d;
  logic              busy_q, busy_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic              cmpl_q, cmpl_d;
  logic              to_q, to_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [SL_W-1:0]   slen_q, slen_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;

  logic [N_CH-1:0]   req;
  logic [CH_W-1:0]   winner;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  assign req = ready & en_mask;

  // Walk from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[rr_idx(ptr_q, i)]) winner = rr_idx(ptr_q, i);
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = '0;
    busy_d   = busy_q;
    grant_d  = grant_q;
    cmpl_d   = 1'b0;
    to_d     = 1'b0;
    err_d    = err_q;
    err_ch_d = err_ch_q;
    ptr_d    = ptr_q;
    slen_d   = slen_q;
    tcnt_d   = tcnt_q;

    if (err_clr) begin
      err_d    = 1'b0;
      err_ch_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          state_d         = ST_START;
          start_d[winner] = 1'b1;
          grant_d         = winner;
          busy_d          = 1'b1;
          ptr_d           = (winner == CH_W'(N_CH - 1)) ? '0 : winner + CH_W'(1);
          slen_d          = '0;
        end
      end
      ST_START: begin
        if (slen_q == SL_W'(START_LEN - 1)) begin
          state_d = ST_WAIT;
          tcnt_d  = '0;
        end else begin
          start_d = start_q;
          slen_d  = slen_q + SL_W'(1);
        end
      end
      ST_WAIT: begin
        // done is checked first so it beats a timeout expiring in the same cycle
        if (done[grant_q]) begin
          state_d = ST_IDLE;
          cmpl_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
          busy_d  = 1'b0;
          if (!err_q || err_clr) begin
            err_d    = 1'b1;
            err_ch_d = grant_q;
          end
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      start_q  <= '0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      cmpl_q   <= 1'b0;
      to_q     <= 1'b0;
      err_q    <= 1'b0;
      err_ch_q <= '0;
      ptr_q    <= '0;
      slen_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      cmpl_q   <= cmpl_d;
      to_q     <= to_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
      ptr_q    <= ptr_d;
      slen_q   <= slen_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign start    = start_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign cmpl     = cmpl_q;
  assign to_pulse = to_q;
  assign err      = err_q;
  assign err_ch   = err_ch_q;

endmodule

// File: tb/tb_handshake_rr_seq.sv
// Directed bench for handshake_rr_seq: grant-order scoreboard plus cycle-exact checks on two parameter sets.
module tb_handshake_rr_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0] ready_a = '0, done_a = '0, en_a = '1;
  logic         err_clr_a = 1'b0;
  logic [N-1:0] start_a;
  logic         busy_a, cmpl_a, to_a, err_a;
  logic [1:0]   gid_a, ech_a;

  logic [N-1:0] ready_b = '0, done_b = '0, en_b = '1;
  logic         err_clr_b = 1'b0;
  logic [N-1:0] start_b;
  logic         busy_b, cmpl_b, to_b, err_b;
  logic [1:0]   gid_b, ech_b;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];
  logic [N-1:0] prev_start = '0;

  always #5 clk = ~clk;

  handshake_rr_seq #(.N_CH(4), .START_LEN(1), .TO_W(8), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .done(done_a), .en_mask(en_a), .err_clr(err_clr_a),
    .start(start_a), .busy(busy_a), .grant_id(gid_a), .cmpl(cmpl_a), .to_pulse(to_a),
    .err(err_a), .err_ch(ech_a)
  );

  handshake_rr_seq #(.N_CH(4), .START_LEN(3), .TO_W(8), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .done(done_b), .en_mask(en_b), .err_clr(err_clr_b),
    .start(start_b), .busy(busy_b), .grant_id(gid_b), .cmpl(cmpl_b), .to_pulse(to_b),
    .err(err_b), .err_ch(ech_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (start_a == '0 && n < 20) begin
      step();
      n++;
    end
    chk("wait_start", 32'(start_a != '0), 32'd1);
  endtask

  // Each new start pulse on dut_a pops the next expected winner.
  always @(negedge clk) begin
    if (start_a != '0 && prev_start == '0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_grant", 32'(start_a), 32'd0);
      end else begin
        int e;
        e = sb_q.pop_front();
        chk("sb_start", 32'(start_a), 32'd1 << e);
        chk("sb_grant_id", 32'(gid_a), 32'(e));
      end
    end
    prev_start = start_a;
  end

  initial begin
    int g;
    // reset state
    step();
    step();
    chk("rst_start", 32'(start_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_grant_id", 32'(gid_a), 0);
    chk("rst_cmpl", 32'(cmpl_a), 0);
    chk("rst_to_pulse", 32'(to_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_err_ch", 32'(ech_a), 0);
    rst = 1'b0;

    // single request, 1-cycle latency, en_mask dropped mid-transaction
    ready_a = 4'b0001;
    sb_q.push_back(0);
    step();
    chk("t1_start", 32'(start_a), 32'b0001);
    chk("t1_busy", 32'(busy_a), 1);
    ready_a = '0;
    step();
    chk("t1_start_len", 32'(start_a), 0);
    en_a = 4'b1110;
    step();
    done_a = 4'b0001;
    step();
    chk("t1_cmpl", 32'(cmpl_a), 1);
    chk("t1_busy_low", 32'(busy_a), 0);
    chk("t1_grant_id", 32'(gid_a), 0);
    done_a = '0;
    en_a = '1;
    step();
    chk("t1_cmpl_pulse", 32'(cmpl_a), 0);

    // round-robin order from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_a = 4'b1111;
    sb_q.push_back(0);
    sb_q.push_back(1);
    sb_q.push_back(2);
    sb_q.push_back(3);
    sb_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_start();
      g = int'(gid_a);
      step();
      step();
      done_a[g] = 1'b1;
      step();
      chk("t2_cmpl", 32'(cmpl_a), 1);
      done_a = '0;
      if (k == 4) ready_a = '0;
    end
    step();

    // START_LEN=3: done during START is ignored
    ready_b = 4'b0100;
    step();
    chk("t3_start_c1", 32'(start_b), 32'b0100);
    ready_b = '0;
    done_b = 4'b0100;
    step();
    chk("t3_start_c2", 32'(start_b), 32'b0100);
    chk("t3_no_cmpl_c2", 32'(cmpl_b), 0);
    step();
    chk("t3_start_c3", 32'(start_b), 32'b0100);
    chk("t3_no_cmpl_c3", 32'(cmpl_b), 0);
    done_b = '0;
    step();
    chk("t3_start_off", 32'(start_b), 0);
    chk("t3_no_cmpl_c4", 32'(cmpl_b), 0);
    step();
    done_b = 4'b0100;
    step();
    chk("t3_cmpl", 32'(cmpl_b), 1);
    done_b = '0;

    // timeout on ch1 (pointer now 1)
    ready_a = 4'b0010;
    sb_q.push_back(1);
    step();
    ready_a = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_no_to", 32'(to_a), 0);
    end
    step();
    chk("t4_to_pulse", 32'(to_a), 1);
    chk("t4_err", 32'(err_a), 1);
    chk("t4_err_ch", 32'(ech_a), 1);
    chk("t4_busy", 32'(busy_a), 0);
    step();
    chk("t4_to_once", 32'(to_a), 0);

    // second timeout on ch3 keeps first error channel
    ready_a = 4'b1000;
    sb_q.push_back(3);
    step();
    ready_a = '0;
    for (int k = 0; k < 9; k++) step();
    chk("t4b_to_pulse", 32'(to_a), 1);
    chk("t4b_err_ch_kept", 32'(ech_a), 1);
    err_clr_a = 1'b1;
    step();
    err_clr_a = 1'b0;
    chk("t4_clr_err", 32'(err_a), 0);
    chk("t4_clr_err_ch", 32'(ech_a), 0);

    // timeout with err_clr held: set wins
    ready_a = 4'b0100;
    sb_q.push_back(2);
    err_clr_a = 1'b1;
    step();
    ready_a = '0;
    for (int k = 0; k < 9; k++) step();
    err_clr_a = 1'b0;
    chk("t4c_to_pulse", 32'(to_a), 1);
    chk("t4c_err_set_wins", 32'(err_a), 1);
    chk("t4c_err_ch", 32'(ech_a), 2);

    // done on the final timeout cycle wins
    ready_a = 4'b1000;
    sb_q.push_back(3);
    step();
    ready_a = '0;
    for (int k = 0; k < 8; k++) step();
    done_a = 4'b1000;
    step();
    done_a = '0;
    chk("t5_cmpl", 32'(cmpl_a), 1);
    chk("t5_no_to", 32'(to_a), 0);
    chk("t5_err_kept", 32'(err_a), 1);
    chk("t5_err_ch_kept", 32'(ech_a), 2);

    // reset in WAIT aborts; pointer returns to 0
    ready_a = 4'b0100;
    sb_q.push_back(2);
    step();
    ready_a = '0;
    step();
    step();
    chk("t6_busy_wait", 32'(busy_a), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_start", 32'(start_a), 0);
    chk("t6_rst_busy", 32'(busy_a), 0);
    chk("t6_rst_grant_id", 32'(gid_a), 0);
    chk("t6_rst_err", 32'(err_a), 0);
    chk("t6_rst_err_ch", 32'(ech_a), 0);
    chk("t6_rst_cmpl", 32'(cmpl_a), 0);
    ready_a = 4'b1010;
    sb_q.push_back(1);
    step();
    chk("t6_lowest_grant", 32'(start_a), 32'b0010);
    chk("t6_no_to_after_rst", 32'(to_a), 0);
    ready_a = '0;
    step();
    done_a = 4'b0010;
    step();
    chk("t6_cmpl", 32'(cmpl_a), 1);
    done_a = '0;
    step();

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_rr_seq.md
Name: handshake_rr_seq

Overview:
Parametrised multi-channel successor of the single start/ready/done handshake used by the SPI transfer path. Arbitrates round-robin among N_CH requesters that signal ready, issues a registered start strobe of configurable length to the winner, then waits for its done. Adds a per-transaction timeout watchdog, a completion strobe and sticky error reporting. Sits between SPI command sources and the SPI engine(s).

Parameters:
N_CH, 4, number of channels (>=2)
START_LEN, 1, start strobe length in cycles (>=1)
TO_W, 16, timeout counter width
TIMEOUT, 1000, WAIT cycles before abort (1..2^TO_W-1)
CH_W, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ready  in  N_CH  per-channel request, level
done  in  N_CH  per-channel completion, level or pulse
en_mask  in  N_CH  1 = channel eligible for grant
err_clr  in  1  clears sticky error state
start  out  N_CH  one-hot start strobe, registered
busy  out  1  high in START and WAIT
grant_id  out  CH_W  index of current/last granted channel
cmpl  out  1  one-cycle pulse on accepted done
to_pulse  out  1  one-cycle pulse on timeout abort
err  out  1  sticky timeout flag
err_ch  out  CH_W  channel of first timeout since clear

Behaviour:
- Reset values (rst=1 at edge): state IDLE, start=0, busy=0, grant_id=0, cmpl=0, to_pulse=0, err=0, err_ch=0, rr pointer=0, counters=0. Reset mid-transaction aborts immediately; no cmpl/to_pulse produced.
- States: IDLE, START, WAIT.
- IDLE: req = ready & en_mask. If req!=0, winner = first set bit searching ptr, ptr+1, ... wrap at N_CH-1->0. Next edge: state START, start[winner]=1, grant_id=winner, busy=1, ptr=(winner+1) mod N_CH. Latency ready->start = 1 cycle.
- START: start held one-hot for exactly START_LEN cycles, then START->WAIT with start=0. done ignored during START. ready/en_mask changes ignored.
- WAIT: timeout counter starts at 0, increments each WAIT cycle. done[grant_id]=1 -> next edge IDLE, cmpl=1 one cycle, busy=0. done on other channels ignored. Counter reaching TIMEOUT-1 with no done -> next edge IDLE, to_pulse=1, busy=0; if err=0 then err=1, err_ch=grant_id (first error kept). done on the same cycle as timeout expiry: done wins (cmpl, no timeout).
- IDLE after completion: earliest next start is 1 cycle after returning to IDLE (min 1 idle cycle between grants). Held ready re-arbitrates normally; rr guarantees no starvation.
- err_clr=1: err=0, err_ch=0 next edge. If a timeout occurs the same cycle, set wins (err=1, err_ch=grant_id).
- en_mask cleared for active channel mid-transaction: transaction completes normally.
- grant_id holds last value while IDLE.
- Counter widths: timeout counter TO_W bits, never wraps (bounded by TIMEOUT).

Test Plan:
- Reset then ready=0001, en_mask=1111, START_LEN=1: start=0001 exactly one cycle after ready; done[0] 3 cycles later -> cmpl pulse, busy low, grant_id=0.
- ready=1111 held, done returned 2 cycles after each start: grant order 0,1,2,3,0; no channel granted twice consecutively.
- START_LEN=3, done[2] asserted during START then dropped: start high 3 cycles, done ignored, later done[2] in WAIT -> cmpl.
- TIMEOUT=8, no done on ch1: to_pulse after 8 WAIT cycles, err=1, err_ch=1; second timeout on ch3 keeps err_ch=1; err_clr -> err=0, err_ch=0.
- done[grant] on final timeout cycle -> cmpl=1, to_pulse=0, err unchanged; rst asserted in WAIT -> all outputs 0 next edge, ptr=0, next grant to lowest ready index.
